// File: rtl/tx_channel_sequencer.sv
// Sequences CH1 then CH2 buffer readout onto the single Tx stream.
// Optional TX_CHANNEL_HEADER_EN inserts a {HEADER_TAG, channel id} word ahead of each channel.
module tx_channel_sequencer #(
    parameter int unsigned TX_DATA_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_CNT_WIDTH   = 11,
    parameter logic [3:0]  HEADER_TAG     = 4'hA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               ch_mask,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic                     ch1_rqst,
    input  logic [TX_DATA_WIDTH-1:0] ch1_data,
    input  logic                     ch1_rdy,
    input  logic                     ch1_eof,
    output logic                     ch1_ack,
    output logic                     ch2_rqst,
    input  logic [TX_DATA_WIDTH-1:0] ch2_data,
    input  logic                     ch2_rdy,
    input  logic                     ch2_eof,
    output logic                     ch2_ack,
    output logic [TX_DATA_WIDTH-1:0] tx_data,
    output logic                     tx_rdy,
    output logic                     tx_eof,
    input  logic                     tx_ack,
    output logic [3:0]               state_dbg
);

    // Handshake: a word moves on a clk edge where rdy=1 and ack=1; rdy holds
    // its word until that edge, and ack never depends on anything but tx_ack.

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_REQ1  = 4'd1,
        S_WAIT1 = 4'd2,
        S_STRM1 = 4'd3,
        S_REQ2  = 4'd4,
        S_WAIT2 = 4'd5,
        S_STRM2 = 4'd6,
        S_FIN   = 4'd7
`ifdef TX_CHANNEL_HEADER_EN
        ,
        S_HDR1  = 4'd8,
        S_HDR2  = 4'd9
`endif
    } state_t;

`ifdef TX_CHANNEL_HEADER_EN
    localparam state_t CH1_ENTRY = S_HDR1;
    localparam state_t CH2_ENTRY = S_HDR2;
`else
    localparam state_t CH1_ENTRY = S_REQ1;
    localparam state_t CH2_ENTRY = S_REQ2;
`endif

    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [1:0]              mask_q, mask_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    terr_q, terr_d;
    logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                    in_hdr;
    logic [3:0]              hdr_id;
    state_t                  after_ch1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mask_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        terr_d    = terr_q;
        cnt_d     = cnt_q;
        ch1_rqst  = 1'b0;
        ch2_rqst  = 1'b0;
        ch1_ack   = 1'b0;
        ch2_ack   = 1'b0;
        tx_data   = '0;
        tx_rdy    = 1'b0;
        tx_eof    = 1'b0;
        in_hdr    = 1'b0;
        hdr_id    = 4'd0;
        after_ch1 = mask_q[1] ? CH2_ENTRY : S_FIN;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    terr_d = 1'b0;
                    busy_d = 1'b1;
                    if (ch_mask[0]) begin
                        state_d = CH1_ENTRY;
                    end else if (ch_mask[1]) begin
                        state_d = CH2_ENTRY;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end

`ifdef TX_CHANNEL_HEADER_EN
            S_HDR1: begin
                in_hdr = 1'b1;
                hdr_id = 4'd1;
                if (tx_ack) begin
                    state_d = S_REQ1;
                end
            end

            S_HDR2: begin
                in_hdr = 1'b1;
                hdr_id = 4'd2;
                if (tx_ack) begin
                    state_d = S_REQ2;
                end
            end
`endif

            S_REQ1: begin
                ch1_rqst = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT1;
            end

            // WAIT routes the channel too, so a word offered on the first
            // ready cycle transfers without an extra bubble.
            S_WAIT1, S_STRM1: begin
                tx_data = ch1_data;
                tx_rdy  = ch1_rdy;
                tx_eof  = ch1_eof & ~mask_q[1];
                ch1_ack = tx_ack;
                if (state_q == S_WAIT1 && !ch1_rdy) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_LAST) begin
                        terr_d  = 1'b1;
                        state_d = after_ch1;
                    end
                end else if (ch1_rdy && tx_ack && ch1_eof) begin
                    state_d = after_ch1;
                end else begin
                    state_d = S_STRM1;
                end
            end

            S_REQ2: begin
                ch2_rqst = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT2;
            end

            S_WAIT2, S_STRM2: begin
                tx_data = ch2_data;
                tx_rdy  = ch2_rdy;
                tx_eof  = ch2_eof;
                ch2_ack = tx_ack;
                if (state_q == S_WAIT2 && !ch2_rdy) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_LAST) begin
                        terr_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end else if (ch2_rdy && tx_ack && ch2_eof) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_STRM2;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_hdr) begin
            tx_data = TX_DATA_WIDTH'({HEADER_TAG, hdr_id});
            tx_rdy  = 1'b1;
            tx_eof  = 1'b0;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_tx_channel_sequencer.sv
// Scoreboard bench for tx_channel_sequencer: channel source models, Tx ack driver,
// negedge+2 monitor popping the expected word queue.
module tb_tx_channel_sequencer;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   ch_mask = 2'b00;
    logic         busy, done, timeout_err;
    logic         ch1_rqst, ch2_rqst, ch1_ack, ch2_ack;
    logic [1:0]   ch_rdy, ch_eof;
    logic [W-1:0] ch_data [2];
    logic [W-1:0] tx_data;
    logic         tx_rdy, tx_eof, tx_ack;
    logic [3:0]   state_dbg;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W:0]   exp_q[$];

    int           ch_n [2];
    logic [W-1:0] ch_base [2];
    bit           ch_mute [2];
    int           ch_idx [2];
    bit           ch_act [2];
    bit           rq_seen [2];
    bit           fire_seen [2];
    int           ack_mode = 0;

    int           cyc = 0;
    int           rq_cnt [2];
    int           rq1_cyc, done_cyc, start_cyc, te_cyc;
    bit           te_seen;
    int           done_cnt, rdy_cyc, xfer_cnt, ack_bad;

    tx_channel_sequencer #(
        .TX_DATA_WIDTH (W),
        .TIMEOUT_CYCLES(TO),
        .TO_CNT_WIDTH  (5),
        .HEADER_TAG    (4'hA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_mask    (ch_mask),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .ch1_rqst   (ch1_rqst),
        .ch1_data   (ch_data[0]),
        .ch1_rdy    (ch_rdy[0]),
        .ch1_eof    (ch_eof[0]),
        .ch1_ack    (ch1_ack),
        .ch2_rqst   (ch2_rqst),
        .ch2_data   (ch_data[1]),
        .ch2_rdy    (ch_rdy[1]),
        .ch2_eof    (ch_eof[1]),
        .ch2_ack    (ch2_ack),
        .tx_data    (tx_data),
        .tx_rdy     (tx_rdy),
        .tx_eof     (tx_eof),
        .tx_ack     (tx_ack),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Channel sources: a word is held until the monitor saw it accepted.
    initial begin
        ch_rdy = 2'b00;
        ch_eof = 2'b00;
        ch_data[0] = '0;
        ch_data[1] = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                if (!rst) begin
                    ch_act[c] = 1'b0;
                end else begin
                    if (fire_seen[c] && ch_act[c]) begin
                        ch_idx[c]++;
                        if (ch_idx[c] >= ch_n[c]) ch_act[c] = 1'b0;
                    end
                    if (rq_seen[c] && !ch_mute[c]) begin
                        ch_act[c] = 1'b1;
                        ch_idx[c] = 0;
                    end
                end
                ch_rdy[c]  = ch_act[c];
                ch_eof[c]  = ch_act[c] && (ch_idx[c] == ch_n[c] - 1);
                ch_data[c] = ch_act[c] ? ch_base[c] + W'(ch_idx[c]) : '0;
            end
        end
    end

    initial begin
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            case (ack_mode)
                0:       tx_ack = 1'b1;
                1:       tx_ack = ~tx_ack;
                default: tx_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: values seen here are what the next posedge will act on.
    initial begin
        logic [W:0] exp_w;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            rq_seen[0]   = ch1_rqst;
            rq_seen[1]   = ch2_rqst;
            fire_seen[0] = ch_rdy[0] && ch1_ack;
            fire_seen[1] = ch_rdy[1] && ch2_ack;
            if (rst) begin
                if (ch1_rqst) begin rq_cnt[0]++; rq1_cyc = cyc; end
                if (ch2_rqst) rq_cnt[1]++;
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (start) start_cyc = cyc;
                if (timeout_err && !te_seen) begin te_seen = 1'b1; te_cyc = cyc; end
                if (tx_rdy) rdy_cyc++;
                if ((ch1_ack && ch2_ack) || (ch1_ack && rq_cnt[0] == 0) || (ch2_ack && rq_cnt[1] == 0))
                    ack_bad++;
                if (tx_rdy && tx_ack) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("tx_extra_word", 32'({tx_eof, tx_data}), 32'hFFFF_FFFF);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check_eq("tx_word", 32'({tx_eof, tx_data}), 32'(exp_w));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        rq_cnt[0] = 0; rq_cnt[1] = 0;
        done_cnt = 0; rdy_cyc = 0; xfer_cnt = 0; ack_bad = 0;
        te_seen = 1'b0; te_cyc = 0; rq1_cyc = 0; done_cyc = 0; start_cyc = 0;
    endtask

    task automatic push_channel(input int hdr_id, input logic [W-1:0] base, input int n,
                                input bit last, input bit mute);
`ifdef TX_CHANNEL_HEADER_EN
        exp_q.push_back({1'b0, 4'hA, 4'(hdr_id)});
`else
        if (hdr_id < 0) exp_q.push_back('0);
`endif
        if (!mute) begin
            for (int i = 0; i < n; i++) exp_q.push_back({last && (i == n - 1), base + W'(i)});
        end
    endtask

    task automatic pulse_start(input logic [1:0] m);
        @(negedge clk);
        start   = 1'b1;
        ch_mask = m;
        @(negedge clk);
        start   = 1'b0;
        ch_mask = ~m;
        #1;
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        for (int g = 0; g < 3000 && done_cnt == 0; g++) @(negedge clk);
        check_eq("done_seen", done_cnt > 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [1:0] m, input int n1, input int n2,
                             input bit mute1, input int amode);
        ch_n[0]    = n1;
        ch_n[1]    = n2;
        ch_base[0] = W'($urandom_range(0, 120));
        ch_base[1] = W'($urandom_range(0, 120));
        ch_mute[0] = mute1;
        ch_mute[1] = 1'b0;
        ack_mode   = amode;
        clear_stats();
        if (m[0]) push_channel(1, ch_base[0], n1, !m[1], mute1);
        if (m[1]) push_channel(2, ch_base[1], n2, 1'b1, 1'b0);
        pulse_start(m);
        wait_done();
        check_eq("ch1_rqst_count", rq_cnt[0], 32'(m[0]));
        check_eq("ch2_rqst_count", rq_cnt[1], 32'(m[1]));
        check_eq("done_count", done_cnt, 1);
        check_eq("words_left", exp_q.size(), 0);
        check_eq("busy_idle", busy, 0);
        check_eq("ack_routing", ack_bad, 0);
        exp_q.delete();
    endtask

    initial begin
        ch_n[0] = 0; ch_n[1] = 0;
        ch_base[0] = '0; ch_base[1] = '0;
        ch_mute[0] = 1'b0; ch_mute[1] = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outputs",
                 32'({busy, done, timeout_err, ch1_rqst, ch2_rqst, ch1_ack, ch2_ack,
                      tx_rdy, tx_eof, tx_data, state_dbg}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Both channels, ack always high.
        run_frame(2'b11, 4, 3, 1'b0, 0);
        check_eq("no_timeout_t1", timeout_err, 0);

        // CH1 only, ack alternating.
        run_frame(2'b01, 5, 3, 1'b0, 1);
        check_eq("xfer_count_t2", xfer_cnt, 32'(5 + (exp_q.size() == 0 ? 0 : 99)
`ifdef TX_CHANNEL_HEADER_EN
                 + 1
`endif
                 ));

        // CH1 silent: skipped after timeout, CH2 still streams.
        run_frame(2'b11, 4, 2, 1'b1, 0);
        check_eq("timeout_delay", te_cyc - rq1_cyc, TO);
        check_eq("timeout_sticky", timeout_err, 1);

        // Empty mask; also clears the sticky error.
        run_frame(2'b00, 1, 1, 1'b0, 0);
        check_eq("done_latency_mask0", done_cyc - start_cyc, 2);
        check_eq("no_tx_rdy_mask0", rdy_cyc, 0);
        check_eq("timeout_cleared", timeout_err, 0);

        // Restart ignored mid-frame, then reset during CH2.
        ch_n[0] = 4; ch_n[1] = 6;
        ch_base[0] = 8'h80; ch_base[1] = 8'h90;
        ch_mute[0] = 1'b0; ch_mute[1] = 1'b0;
        ack_mode = 0;
        clear_stats();
        push_channel(1, 8'h80, 4, 1'b0, 1'b0);
        push_channel(2, 8'h90, 6, 1'b1, 1'b0);
        pulse_start(2'b11);
        for (int g = 0; g < 200 && !(ch_act[0] && xfer_cnt >= 2); g++) @(negedge clk);
        start = 1'b1;
        ch_mask = 2'b01;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 200 && !(rq_cnt[1] == 1 && ch_idx[1] >= 2); g++) @(negedge clk);
        check_eq("ch2_reached", rq_cnt[1], 1);
        rst = 1'b0;
        #1;
        check_eq("midframe_reset_outputs",
                 32'({busy, done, timeout_err, ch1_rqst, ch2_rqst, ch1_ack, ch2_ack,
                      tx_rdy, tx_eof, tx_data, state_dbg}), 0);
        repeat (3) @(negedge clk);
        check_eq("no_done_on_reset", done_cnt, 0);
        check_eq("ch1_rqst_once", rq_cnt[0], 1);
        exp_q.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Randomised frames.
        for (int k = 0; k < 4; k++) begin
            run_frame(2'($urandom_range(1, 3)), $urandom_range(1, 6), $urandom_range(1, 6), 1'b0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
